// File: rtl/wb_writer.sv
// -----------------------------------------------------------------------------
// wb_writer
//
// Drives the register file's single write port. Two producers share the port.
//   * The MEM/WB pipeline result is always accepted and always wins.
//   * The multi-cycle mul/div unit hands over results with a valid/ready
//     handshake. They go into a small in-order buffer, which drains whenever
//     the pipeline leaves the port idle.
// The rf_* outputs are registered on the rising edge, so the register file
// can capture them on the falling edge of the same cycle.
//
// A pipeline write to register R is always newer than any buffered mul/div
// result for R. It therefore kills those entries (WAW). A killed entry keeps
// its slot until it reaches the head, where it is retired without a write.
//
// Ports
//   clk        system clock; all state changes on posedge
//   reset      asynchronous, active-low; clears all state
//   pipe_wr    MEM/WB requests a register write this cycle
//   pipe_addr  pipeline destination register
//   pipe_data  pipeline write data
//   md_valid   mul/div unit offers a result
//   md_addr    mul/div destination register
//   md_data    mul/div result
//   md_ready   buffer can accept a mul/div result this cycle
//   rf_wr      register file write enable (registered)
//   rf_addr    register file write address (registered)
//   rf_data    register file write data (registered)
//   pend_busy  bit i set while a live buffered write to register i is pending
// -----------------------------------------------------------------------------
module wb_writer #(
  parameter int MD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wr,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] pend_busy
);

  localparam int PW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int CW = PW + 1;

  // Buffer state. The depth is a power of two, so the pointers wrap on
  // their own.
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [MD_DEPTH-1:0] live;
  logic [4:0]          buf_addr [MD_DEPTH];
  logic [31:0]         buf_data [MD_DEPTH];

  // Per-cycle decisions
  logic pipe_valid;
  logic md_accept;
  logic push;
  logic pop;
  logic head_live;

  // ---------------------------------------------------------------------------
  // Handshake and arbitration
  // ---------------------------------------------------------------------------
  // md_ready depends only on the registered count. A pop in this cycle does
  // not free a slot for a push in the same cycle, so there is no
  // combinational path from the pipeline inputs to md_ready.
  assign md_ready   = (count < CW'(MD_DEPTH));
  assign md_accept  = md_valid && md_ready;
  assign pipe_valid = pipe_wr && (pipe_addr != 5'd0);

  // An accepted result is consumed without creating an entry in two cases.
  // It targets r0. Or a pipeline write to the same register lands at this
  // edge, which makes the result stale before it is even stored.
  assign push = md_accept && (md_addr != 5'd0) &&
                !(pipe_valid && (pipe_addr == md_addr));

  // The buffer drains only when the pipeline leaves the port idle. Dead
  // entries pop the same way, so their slots come back.
  assign pop       = !pipe_valid && (count != '0);
  assign head_live = live[head];

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Live bits: kill, retire and fill
  // ---------------------------------------------------------------------------
  // A pushed slot is never the head being popped, because a push needs
  // count < MD_DEPTH. A push is also suppressed when its address matches
  // the killing pipeline write. So the three updates never fight over the
  // same live bit in a way that matters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= '0;
    end else begin
      for (int i = 0; i < MD_DEPTH; i++) begin
        if (pipe_valid && (buf_addr[i] == pipe_addr)) live[i] <= 1'b0;
      end
      if (pop)  live[head] <= 1'b0;
      if (push) live[tail] <= 1'b1;
    end
  end

  // NOTE: the payload storage has no reset. Nothing reads an entry unless
  // its live bit is set, and the live bits are cleared by reset, so clearing
  // the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= md_addr;
      buf_data[tail] <= md_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  // rf_addr and rf_data hold their last values on idle cycles and when a hole
  // is retired. Only rf_wr tells the register file whether to write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr   <= 1'b0;
      rf_addr <= 5'd0;
      rf_data <= 32'd0;
    end else if (pipe_valid) begin
      rf_wr   <= 1'b1;
      rf_addr <= pipe_addr;
      rf_data <= pipe_data;
    end else if (pop && head_live) begin
      rf_wr   <= 1'b1;
      rf_addr <= buf_addr[head];
      rf_data <= buf_data[head];
    end else begin
      rf_wr   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard for the hazard unit
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any conditional
  // update. This keeps the block free of inferred latches.
  always_comb begin
    pend_busy = 32'd0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      if (live[i]) pend_busy[buf_addr[i]] = 1'b1;
    end
    // Entries for r0 are never created. Clearing bit 0 here keeps it
    // constant all the same.
    pend_busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_writer.sv
// -----------------------------------------------------------------------------
// tb_wb_writer
//
// Directed bench for wb_writer with MD_DEPTH = 2. Inputs change 1 ns after a
// rising edge. Outputs are checked 1 ns after the edge that should produce
// them. All expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_wb_writer;

  logic        clk;
  logic        reset;
  logic        pipe_wr;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pend_busy;

  int tests_run;
  int tests_failed;

  wb_writer #(.MD_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_wr   (pipe_wr),
    .pipe_addr (pipe_addr),
    .pipe_data (pipe_data),
    .md_valid  (md_valid),
    .md_addr   (md_addr),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .rf_wr     (rf_wr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .pend_busy (pend_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] mdat);
    pipe_wr   = pw;
    pipe_addr = pa;
    pipe_data = pd;
    md_valid  = mv;
    md_addr   = ma;
    md_data   = mdat;
  endtask

  task automatic check_rf(input string tag, input logic wr, input logic [4:0] a,
                          input logic [31:0] d);
    check({tag, ".rf_wr"},   {31'd0, rf_wr}, {31'd0, wr});
    check({tag, ".rf_addr"}, {27'd0, rf_addr}, {27'd0, a});
    check({tag, ".rf_data"}, rf_data, d);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // ---------------- Reset state ----------------
    step();
    step();
    check_rf("reset", 1'b0, 5'd0, 32'd0);
    check("reset.md_ready", {31'd0, md_ready}, 32'd1);
    check("reset.pend_busy", pend_busy, 32'd0);

    reset = 1'b1;
    step();
    check_rf("idle_after_reset", 1'b0, 5'd0, 32'd0);
    check("idle_after_reset.pend_busy", pend_busy, 32'd0);

    // ---------------- Pipeline write ----------------
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("pipe_w5", 1'b1, 5'd5, 32'h1234_5678);

    // A write to r0 is dropped. The address and data hold their old values.
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("pipe_r0", 1'b0, 5'd5, 32'h1234_5678);

    // ---------------- Priority and buffering ----------------
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hAAAA);
    step();
    check_rf("prio1", 1'b1, 5'd1, 32'h1);
    check("prio1.pend_busy", pend_busy, 32'h80);
    check("prio1.md_ready", {31'd0, md_ready}, 32'd1);

    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'hBBBB);
    step();
    check_rf("prio2", 1'b1, 5'd2, 32'h2);
    check("prio2.pend_busy", pend_busy, 32'h180);
    check("prio2.md_ready", {31'd0, md_ready}, 32'd0);

    // The buffer is full, so this offer must be ignored.
    drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'hCCCC);
    step();
    check_rf("full", 1'b1, 5'd4, 32'h4);
    check("full.pend_busy", pend_busy, 32'h180);
    check("full.md_ready", {31'd0, md_ready}, 32'd0);

    // The pipeline stops, so the buffer drains in order.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("drain7", 1'b1, 5'd7, 32'hAAAA);
    check("drain7.pend_busy", pend_busy, 32'h100);
    check("drain7.md_ready", {31'd0, md_ready}, 32'd1);
    step();
    check_rf("drain8", 1'b1, 5'd8, 32'hBBBB);
    check("drain8.pend_busy", pend_busy, 32'h0);
    check("drain8.md_ready", {31'd0, md_ready}, 32'd1);
    step();
    check_rf("drained", 1'b0, 5'd8, 32'hBBBB);

    // ---------------- WAW kill ----------------
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd9, 32'h1111);
    step();
    check("waw_buf.pend_busy", pend_busy, 32'h200);
    drive(1'b1, 5'd9, 32'h2222, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("waw_kill", 1'b1, 5'd9, 32'h2222);
    check("waw_kill.pend_busy", pend_busy, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("waw_hole", 1'b0, 5'd9, 32'h2222);
    check("waw_hole.md_ready", {31'd0, md_ready}, 32'd1);
    step();
    check_rf("waw_empty", 1'b0, 5'd9, 32'h2222);

    // ---------------- Simultaneous push and kill ----------------
    drive(1'b1, 5'd3, 32'h4444, 1'b1, 5'd3, 32'h3333);
    step();
    check_rf("simul", 1'b1, 5'd3, 32'h4444);
    check("simul.pend_busy", pend_busy, 32'h0);
    check("simul.md_ready", {31'd0, md_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("simul_after", 1'b0, 5'd3, 32'h4444);

    // ---------------- Push and pop in the same cycle (pointer wrap) ----------------
    drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd14, 32'hE0);
    step();
    check("pp_fill.pend_busy", pend_busy, 32'h4000);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF0);
    step();
    check_rf("pp_pop14", 1'b1, 5'd14, 32'hE0);
    check("pp_pop14.pend_busy", pend_busy, 32'h8000);
    check("pp_pop14.md_ready", {31'd0, md_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check_rf("pp_pop15", 1'b1, 5'd15, 32'hF0);
    check("pp_pop15.pend_busy", pend_busy, 32'h0);

    // ---------------- Mid-operation reset ----------------
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'hC12);
    step();
    drive(1'b1, 5'd11, 32'h22, 1'b1, 5'd13, 32'hC13);
    step();
    check("mid.pend_busy", pend_busy, 32'h3000);
    check("mid.md_ready", {31'd0, md_ready}, 32'd0);
    check_rf("mid", 1'b1, 5'd11, 32'h22);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    reset = 1'b0;  // asserted between edges, so outputs must clear at once
    #1;
    check_rf("async_rst", 1'b0, 5'd0, 32'd0);
    check("async_rst.pend_busy", pend_busy, 32'h0);
    check("async_rst.md_ready", {31'd0, md_ready}, 32'd1);
    step();
    reset = 1'b1;
    step();
    check_rf("post_rst1", 1'b0, 5'd0, 32'd0);
    step();
    check_rf("post_rst2", 1'b0, 5'd0, 32'd0);
    check("post_rst2.pend_busy", pend_busy, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
